// File: rtl/cosim_commit_serializer.sv
// Retire-order commit serializer: takes up to two retiring instructions per cycle and emits one commit record per cycle.
// Latency: 2 cycles from wb valid to cosim_valid when empty. No backpressure: records that do not fit are dropped and overflow is raised.
module cosim_commit_serializer #(
  parameter int DEPTH       = 8,
  parameter int HANG_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb0_valid,
  input  logic [63:0]                wb0_pc,
  input  logic [31:0]                wb0_inst,
  input  logic                       wb0_we,
  input  logic [4:0]                 wb0_rd,
  input  logic [63:0]                wb0_wdata,
  input  logic                       wb1_valid,
  input  logic [63:0]                wb1_pc,
  input  logic [31:0]                wb1_inst,
  input  logic                       wb1_we,
  input  logic [4:0]                 wb1_rd,
  input  logic [63:0]                wb1_wdata,
  output logic                       cosim_valid,
  output logic [63:0]                cosim_pc,
  output logic [31:0]                cosim_inst,
  output logic                       cosim_we,
  output logic [4:0]                 cosim_rd,
  output logic [63:0]                cosim_wdate,
  output logic [63:0]                commit_count,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic                       hang
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(HANG_CYCLES + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          rec0, rec1, head_rec;
  logic [AW-1:0] head, tail, slot1;
  logic [CW-1:0] count, free, n_acc;
  logic [IW-1:0] idle, idle_next;
  logic          pop, acc0, acc1, drop;

  always_comb begin
    // x0 writes are masked at push time so the checker never sees them
    rec0      = '{wb0_pc, wb0_inst, wb0_we && (wb0_rd != 5'd0), wb0_rd, wb0_wdata};
    rec1      = '{wb1_pc, wb1_inst, wb1_we && (wb1_rd != 5'd0), wb1_rd, wb1_wdata};
    head_rec  = mem[head];
    pop       = (count != '0);
    free      = CW'(DEPTH) - count + CW'(pop);
    acc0      = wb0_valid && (free != '0);
    acc1      = wb1_valid && (wb0_valid ? (free >= CW'(2)) : (free != '0));
    n_acc     = CW'(acc0) + CW'(acc1);
    slot1     = wb0_valid ? tail + AW'(1) : tail;
    drop      = (wb0_valid && !acc0) || (wb1_valid && !acc1);
    idle_next = idle;
    if (cosim_valid) begin
      idle_next = '0;
    end else if (idle != IW'(HANG_CYCLES)) begin
      idle_next = idle + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem[tail]  <= rec0;
    if (acc1) mem[slot1] <= rec1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      cosim_valid  <= 1'b0;
      cosim_pc     <= '0;
      cosim_inst   <= '0;
      cosim_we     <= 1'b0;
      cosim_rd     <= '0;
      cosim_wdate  <= '0;
      commit_count <= '0;
      overflow     <= 1'b0;
      hang         <= 1'b0;
      idle         <= '0;
    end else begin
      tail        <= tail + AW'(n_acc);
      head        <= head + AW'(pop);
      count       <= count + n_acc - CW'(pop);
      cosim_valid <= pop;
      if (pop) begin
        cosim_pc    <= head_rec.pc;
        cosim_inst  <= head_rec.inst;
        cosim_we    <= head_rec.we;
        cosim_rd    <= head_rec.rd;
        cosim_wdate <= head_rec.wdata;
      end
      commit_count <= commit_count + 64'(pop);
      overflow     <= overflow | drop;
      idle         <= idle_next;
      hang         <= hang | (idle_next == IW'(HANG_CYCLES));
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_cosim_commit_serializer.sv
// Directed self-checking bench for cosim_commit_serializer (DEPTH=8, HANG_CYCLES=16).
module tb_cosim_commit_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb0_valid, wb0_we, wb1_valid, wb1_we;
  logic [63:0] wb0_pc, wb0_wdata, wb1_pc, wb1_wdata;
  logic [31:0] wb0_inst, wb1_inst;
  logic [4:0]  wb0_rd, wb1_rd;
  logic        cosim_valid, cosim_we, overflow, hang;
  logic [63:0] cosim_pc, cosim_wdate, commit_count;
  logic [31:0] cosim_inst;
  logic [4:0]  cosim_rd;
  logic [3:0]  occupancy;

  int n_cmp = 0;
  int n_fail = 0;

  cosim_commit_serializer #(.DEPTH(8), .HANG_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_pc(wb0_pc), .wb0_inst(wb0_inst), .wb0_we(wb0_we),
    .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata),
    .wb1_valid(wb1_valid), .wb1_pc(wb1_pc), .wb1_inst(wb1_inst), .wb1_we(wb1_we),
    .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata),
    .cosim_valid(cosim_valid), .cosim_pc(cosim_pc), .cosim_inst(cosim_inst),
    .cosim_we(cosim_we), .cosim_rd(cosim_rd), .cosim_wdate(cosim_wdate),
    .commit_count(commit_count), .occupancy(occupancy), .overflow(overflow), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic clear_lanes();
    wb0_valid = 0; wb0_pc = '0; wb0_inst = '0; wb0_we = 0; wb0_rd = '0; wb0_wdata = '0;
    wb1_valid = 0; wb1_pc = '0; wb1_inst = '0; wb1_we = 0; wb1_rd = '0; wb1_wdata = '0;
  endtask

  task automatic set_lane(input int lane, input logic [63:0] pc, input logic [31:0] inst,
                          input logic we, input logic [4:0] rd, input logic [63:0] wdata);
    if (lane == 0) begin
      wb0_valid = 1; wb0_pc = pc; wb0_inst = inst; wb0_we = we; wb0_rd = rd; wb0_wdata = wdata;
    end else begin
      wb1_valid = 1; wb1_pc = pc; wb1_inst = inst; wb1_we = we; wb1_rd = rd; wb1_wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset is released on a falling edge; the next rising edge is the first after release.
  task automatic do_reset();
    clear_lanes();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // Drives a program-ordered burst (pc = 0x1000 + 4*i) and collects the emitted stream.
  task automatic run_burst(input int cycles, input bit last_dual, output int emitted,
                           output int max_occ, output int order_errs, output logic ovf_mid);
    int nxt;
    nxt = 0; max_occ = 0; order_errs = 0; ovf_mid = 0;
    for (int k = 0; k < cycles + 24; k++) begin
      clear_lanes();
      if (k < cycles) begin
        set_lane(0, 64'h1000 + 64'(8 * k), 32'h13, 1'b1, 5'd1, 64'(k));
        if (k < cycles - 1 || last_dual)
          set_lane(1, 64'h1000 + 64'(8 * k + 4), 32'h13, 1'b1, 5'd2, 64'(k));
      end
      step();
      if (k == cycles - 2) ovf_mid = overflow;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (cosim_valid) begin
        if (cosim_pc !== 64'h1000 + 64'(4 * nxt)) order_errs++;
        nxt++;
      end
    end
    clear_lanes();
    emitted = nxt;
  endtask

  task automatic test_reset();
    clear_lanes();
    #1 rst = 1;
    #1;
    n_cmp++; if (cosim_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", cosim_valid); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    n_cmp++; if (commit_count !== 64'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", commit_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_cmp++; if (hang !== 1'b0) begin n_fail++; $display("FAIL reset_hang: got %b expected 0", hang); end
    n_cmp++; if (cosim_pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", cosim_pc); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single_lane();
    do_reset();
    set_lane(0, 64'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 64'd5);
    step();
    clear_lanes();
    n_cmp++; if (cosim_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b expected 0", cosim_valid); end
    n_cmp++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL single_occ: got %0d expected 1", occupancy); end
    step();
    n_cmp++; if (cosim_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", cosim_valid); end
    n_cmp++; if (cosim_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL single_pc: got %h expected 80000000", cosim_pc); end
    n_cmp++; if (cosim_inst !== 32'h0050_0093) begin n_fail++; $display("FAIL single_inst: got %h expected 00500093", cosim_inst); end
    n_cmp++; if (cosim_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", cosim_we); end
    n_cmp++; if (cosim_rd !== 5'd1) begin n_fail++; $display("FAIL single_rd: got %0d expected 1", cosim_rd); end
    n_cmp++; if (cosim_wdate !== 64'd5) begin n_fail++; $display("FAIL single_wdata: got %0d expected 5", cosim_wdate); end
    step();
    n_cmp++; if (cosim_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", cosim_valid); end
    n_cmp++; if (cosim_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL single_hold: got %h expected 80000000", cosim_pc); end
    n_cmp++; if (commit_count !== 64'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", commit_count); end
  endtask

  task automatic test_dual_retire();
    do_reset();
    set_lane(0, 64'h100, 32'h0030_0193, 1'b1, 5'd3, 64'h33);
    set_lane(1, 64'h104, 32'h0000_0013, 1'b1, 5'd0, 64'h44);
    step();
    clear_lanes();
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL dual_occ2: got %0d expected 2", occupancy); end
    step();
    n_cmp++; if (cosim_valid !== 1'b1 || cosim_pc !== 64'h100) begin n_fail++; $display("FAIL dual_first: got v=%b pc=%h expected v=1 pc=100", cosim_valid, cosim_pc); end
    n_cmp++; if (cosim_we !== 1'b1) begin n_fail++; $display("FAIL dual_first_we: got %b expected 1", cosim_we); end
    n_cmp++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL dual_occ1: got %0d expected 1", occupancy); end
    step();
    n_cmp++; if (cosim_valid !== 1'b1 || cosim_pc !== 64'h104) begin n_fail++; $display("FAIL dual_second: got v=%b pc=%h expected v=1 pc=104", cosim_valid, cosim_pc); end
    n_cmp++; if (cosim_we !== 1'b0) begin n_fail++; $display("FAIL dual_x0_mask: got %b expected 0", cosim_we); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL dual_occ0: got %0d expected 0", occupancy); end
    step();
    n_cmp++; if (cosim_valid !== 1'b0) begin n_fail++; $display("FAIL dual_end: got %b expected 0", cosim_valid); end
  endtask

  task automatic test_lane1_only();
    do_reset();
    set_lane(1, 64'h200, 32'h0070_0393, 1'b1, 5'd7, 64'h55);
    step();
    clear_lanes();
    n_cmp++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL lane1_occ: got %0d expected 1", occupancy); end
    step();
    n_cmp++; if (cosim_valid !== 1'b1 || cosim_pc !== 64'h200) begin n_fail++; $display("FAIL lane1_rec: got v=%b pc=%h expected v=1 pc=200", cosim_valid, cosim_pc); end
    n_cmp++; if (cosim_rd !== 5'd7 || cosim_wdate !== 64'h55 || cosim_we !== 1'b1) begin n_fail++; $display("FAIL lane1_fields: got rd=%0d wd=%h we=%b expected rd=7 wd=55 we=1", cosim_rd, cosim_wdate, cosim_we); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL lane1_drain: got %0d expected 0", occupancy); end
    step();
    n_cmp++; if (cosim_valid !== 1'b0) begin n_fail++; $display("FAIL lane1_once: got %b expected 0", cosim_valid); end
  endtask

  // 8 dual-push cycles: 16 offered, the FIFO is full after the 7th, the 16th record is dropped.
  task automatic test_overflow();
    int emitted, max_occ, order_errs;
    logic ovf_mid;
    do_reset();
    run_burst(8, 1'b1, emitted, max_occ, order_errs, ovf_mid);
    n_cmp++; if (max_occ != 8) begin n_fail++; $display("FAIL ovf_max_occ: got %0d expected 8", max_occ); end
    n_cmp++; if (ovf_mid !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ovf_mid); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_cmp++; if (emitted != 15) begin n_fail++; $display("FAIL ovf_emitted: got %0d expected 15", emitted); end
    n_cmp++; if (order_errs != 0) begin n_fail++; $display("FAIL ovf_order: got %0d out-of-order expected 0", order_errs); end
    do_reset();
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_flag: got %b expected 0", overflow); end
    n_cmp++; if (occupancy !== 4'd0 || cosim_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_state: got occ=%0d v=%b expected occ=0 v=0", occupancy, cosim_valid); end
  endtask

  // Full FIFO with one push and one pop in the same cycle accepts the push without overflow.
  task automatic test_full_push_pop();
    int emitted, max_occ, order_errs;
    logic ovf_mid;
    do_reset();
    run_burst(8, 1'b0, emitted, max_occ, order_errs, ovf_mid);
    n_cmp++; if (max_occ != 8) begin n_fail++; $display("FAIL full_max_occ: got %0d expected 8", max_occ); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
    n_cmp++; if (emitted != 15 || order_errs != 0) begin n_fail++; $display("FAIL full_stream: got %0d recs %0d errs expected 15 recs 0 errs", emitted, order_errs); end
    n_cmp++; if (commit_count !== 64'd15) begin n_fail++; $display("FAIL full_count: got %0d expected 15", commit_count); end
  endtask

  task automatic test_hang();
    do_reset();
    repeat (15) step();
    n_cmp++; if (hang !== 1'b0) begin n_fail++; $display("FAIL hang_early: got %b expected 0", hang); end
    step();
    n_cmp++; if (hang !== 1'b1) begin n_fail++; $display("FAIL hang_rise: got %b expected 1", hang); end
    set_lane(0, 64'h300, 32'h13, 1'b0, 5'd0, 64'd0);
    step();
    clear_lanes();
    step();
    n_cmp++; if (cosim_valid !== 1'b1) begin n_fail++; $display("FAIL hang_commit: got %b expected 1", cosim_valid); end
    step();
    n_cmp++; if (hang !== 1'b1) begin n_fail++; $display("FAIL hang_sticky: got %b expected 1", hang); end
  endtask

  task automatic test_reset_mid_stream();
    int stale;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 64'h400 + 64'(8 * k), 32'h13, 1'b1, 5'd4, 64'(k));
      set_lane(1, 64'h404 + 64'(8 * k), 32'h13, 1'b1, 5'd5, 64'(k));
      step();
    end
    clear_lanes();
    n_cmp++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL mid_occ5: got %0d expected 5", occupancy); end
    #2 rst = 1;
    #1;
    n_cmp++; if (cosim_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", cosim_valid); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL mid_async_occ: got %0d expected 0", occupancy); end
    @(negedge clk);
    rst = 0;
    stale = 0;
    repeat (12) begin
      step();
      if (cosim_valid) stale++;
    end
    n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL mid_stale: got %0d records expected 0", stale); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_dual_retire();
    test_lane1_only();
    test_overflow();
    test_full_push_pop();
    test_hang();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
